// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: datapath widths, bubble encoding, fetch FSM states
// and the IF/ID payload consumed by the decode stage.
package cpu_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [PC_W-1:0]    pc_plus1;
        logic               valid;
    } ifid_t;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: load a fetched instruction, hold, or inject a bubble.
module ifid_reg
    import cpu_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  bubble,
    input  ifid_t d,
    output ifid_t q
);

    localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus1: '0, valid: 1'b0};

    // Bubble wins over load; neither asserted means hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= BUBBLE;
        end else if (bubble) begin
            q <= BUBBLE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction
// memory and fills IF/ID. Handles stall, redirect-with-flush and halt once the
// PC leaves the memory range.
// Optional build macro FETCH_PERF_EN adds saturating fetch/stall counters.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 8,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic [PC_W-1:0]    imem_pc_o,
    input  logic [INSTR_W-1:0] imem_instr_i,
    output logic [INSTR_W-1:0] ifid_instr_o,
    output logic [PC_W-1:0]    ifid_pc_o,
    output logic [PC_W-1:0]    ifid_pc_plus1_o,
    output logic               ifid_valid_o,
    output logic               halted_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        fetch_count_o,
    output logic [31:0]        stall_count_o
`endif
);

    localparam logic [PC_W-1:0] DEPTH_PC = PC_W'(IMEM_DEPTH);
    localparam logic [PC_W-1:0] RST_PC   = PC_W'(RESET_PC);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc;
    logic            ifid_load, ifid_bubble;
    ifid_t           ifid_d, ifid_q;

    assign pc_inc    = pc_q + PC_W'(1);
    assign imem_pc_o = pc_q;

    // Next PC, next state and IF/ID control, in redirect > stall > fetch/halt order.
    always_comb begin
        pc_d        = pc_q;
        state_d     = state_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_d      = '{instr: imem_instr_i, pc: pc_q, pc_plus1: pc_inc, valid: 1'b1};
        if (redirect_i) begin
            pc_d        = redirect_pc_i;
            ifid_bubble = 1'b1;
            state_d     = (redirect_pc_i < DEPTH_PC) ? FETCH : HALT;
        end else if (stall_i) begin
            pc_d = pc_q;
        end else if (state_q == FETCH) begin
            ifid_load = 1'b1;
            pc_d      = pc_inc;
            if (pc_inc == DEPTH_PC) begin
                state_d = HALT;
            end
        end else begin
            ifid_bubble = 1'b1;
        end
    end

    // PC, FSM state and registered halt flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RST_PC;
            state_q  <= FETCH;
            halted_o <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            state_q  <= state_d;
            halted_o <= (state_d == HALT);
        end
    end

    ifid_reg u_ifid_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (ifid_load),
        .bubble (ifid_bubble),
        .d      (ifid_d),
        .q      (ifid_q)
    );

    assign ifid_instr_o    = ifid_q.instr;
    assign ifid_pc_o       = ifid_q.pc;
    assign ifid_pc_plus1_o = ifid_q.pc_plus1;
    assign ifid_valid_o    = ifid_q.valid;

`ifdef FETCH_PERF_EN
    logic stall_event;
    assign stall_event = stall_i && !redirect_i && (state_q == FETCH);

    // Saturating counters of valid loads and in-FETCH stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_o <= '0;
            stall_count_o <= '0;
        end else begin
            if (ifid_load && (fetch_count_o != 32'hFFFF_FFFF)) begin
                fetch_count_o <= fetch_count_o + 32'd1;
            end
            if (stall_event && (stall_count_o != 32'hFFFF_FFFF)) begin
                stall_count_o <= stall_count_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// stall/redirect traffic against a behavioural fetch model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc1;
    logic        ifid_valid;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] fcnt;
    logic [31:0] scnt;
`endif

    logic [31:0] mem [8];
    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic        m_halt;
    logic [31:0] m_instr, m_ipc, m_ipc1;
    logic        m_valid;
    logic [31:0] m_fc, m_sc;

    always #5 clk = ~clk;

    assign imem_instr = (imem_pc < 32'd8) ? mem[imem_pc[2:0]] : 32'hBAD0_BAD0;

    fetch_stage #(.IMEM_DEPTH(8), .RESET_PC(0)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall),
        .redirect_i      (redirect),
        .redirect_pc_i   (redirect_pc),
        .imem_pc_o       (imem_pc),
        .imem_instr_i    (imem_instr),
        .ifid_instr_o    (ifid_instr),
        .ifid_pc_o       (ifid_pc),
        .ifid_pc_plus1_o (ifid_pc1),
        .ifid_valid_o    (ifid_valid),
        .halted_o        (halted)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count_o   (fcnt),
        .stall_count_o   (scnt)
`endif
    );

    task automatic load_mem_default();
        for (int i = 0; i < 8; i++) mem[i] = 32'h11 + 32'(i);
    endtask

    task automatic model_reset();
        m_pc = 0; m_halt = 0; m_instr = 0; m_ipc = 0; m_ipc1 = 0; m_valid = 0;
        m_fc = 0; m_sc = 0;
    endtask

    task automatic model_bubble();
        m_instr = 0; m_ipc = 0; m_ipc1 = 0; m_valid = 0;
    endtask

    // One clock edge of fetch behaviour, described from the stage's rules.
    task automatic model_step();
        if (redirect) begin
            m_pc = redirect_pc;
            model_bubble();
            m_halt = (redirect_pc >= 32'd8);
        end else if (stall) begin
            if (!m_halt && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
        end else if (!m_halt) begin
            m_instr = mem[m_pc[2:0]];
            m_ipc = m_pc;
            m_ipc1 = m_pc + 1;
            m_valid = 1;
            m_pc = m_pc + 1;
            if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
            if (m_pc == 32'd8) m_halt = 1;
        end else begin
            model_bubble();
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; stall = 0; redirect = 0; redirect_pc = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 0;
        #2;
        checks++; if (imem_pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %h exp 0", imem_pc); end
        checks++; if (ifid_instr !== 32'd0) begin errors++; $display("FAIL reset_instr got %h exp 0", ifid_instr); end
        checks++; if (ifid_pc !== 32'd0 || ifid_pc1 !== 32'd0) begin errors++; $display("FAIL reset_ifid_pc got %h/%h exp 0/0", ifid_pc, ifid_pc1); end
        checks++; if (ifid_valid !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL reset_flags got v%b h%b exp v0 h0", ifid_valid, halted); end
        do_reset();
    endtask

    task automatic test_run();
        do_reset();
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 1) begin
                checks++; if (ifid_instr !== 32'h11 || ifid_pc !== 0 || ifid_pc1 !== 1 || ifid_valid !== 1)
                    begin errors++; $display("FAIL run_edge1 got %h pc%0d pc1%0d v%b exp 11 pc0 pc1 1 v1", ifid_instr, ifid_pc, ifid_pc1, ifid_valid); end
            end
            if (e == 8) begin
                checks++; if (ifid_instr !== 32'h18 || halted !== 1)
                    begin errors++; $display("FAIL run_edge8 got %h h%b exp 18 h1", ifid_instr, halted); end
            end
            if (e >= 9) begin
                checks++; if (ifid_valid !== 0 || ifid_instr !== 32'd0 || imem_pc !== 32'd8)
                    begin errors++; $display("FAIL run_halt_bubble e%0d got v%b %h pc%0d exp v0 0 pc8", e, ifid_valid, ifid_instr, imem_pc); end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (3) tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (imem_pc !== 32'd3 || ifid_instr !== 32'h13 || ifid_pc !== 32'd2)
                begin errors++; $display("FAIL stall_hold%0d got pc%0d %h ipc%0d exp pc3 13 ipc2", i, imem_pc, ifid_instr, ifid_pc); end
        end
        stall = 0;
        tick();
        checks++; if (ifid_instr !== 32'h14 || ifid_pc !== 32'd3 || imem_pc !== 32'd4)
            begin errors++; $display("FAIL stall_release got %h ipc%0d pc%0d exp 14 ipc3 pc4", ifid_instr, ifid_pc, imem_pc); end
    endtask

    task automatic test_redirect_stall();
        do_reset();
        repeat (2) tick();
        stall = 1; redirect = 1; redirect_pc = 6;
        tick();
        checks++; if (ifid_valid !== 0 || ifid_instr !== 32'd0 || ifid_pc !== 32'd0 || imem_pc !== 32'd6)
            begin errors++; $display("FAIL redir_stall got v%b %h ipc%0d pc%0d exp v0 0 ipc0 pc6", ifid_valid, ifid_instr, ifid_pc, imem_pc); end
        redirect = 0;
        tick();
        checks++; if (ifid_valid !== 0 || imem_pc !== 32'd6)
            begin errors++; $display("FAIL redir_wait got v%b pc%0d exp v0 pc6", ifid_valid, imem_pc); end
        stall = 0;
        tick();
        checks++; if (ifid_instr !== 32'h17 || ifid_pc !== 32'd6 || ifid_valid !== 1)
            begin errors++; $display("FAIL redir_target got %h ipc%0d v%b exp 17 ipc6 v1", ifid_instr, ifid_pc, ifid_valid); end
    endtask

    task automatic test_halt_redirect();
        do_reset();
        repeat (9) tick();
        checks++; if (halted !== 1) begin errors++; $display("FAIL halt_reached got %b exp 1", halted); end
        redirect = 1; redirect_pc = 1;
        tick();
        checks++; if (halted !== 0 || ifid_valid !== 0) begin errors++; $display("FAIL halt_exit got h%b v%b exp h0 v0", halted, ifid_valid); end
        redirect = 0;
        tick();
        checks++; if (ifid_instr !== 32'h12 || ifid_pc !== 32'd1 || ifid_pc1 !== 32'd2 || ifid_valid !== 1)
            begin errors++; $display("FAIL halt_refetch got %h ipc%0d pc1 %0d v%b exp 12 1 2 v1", ifid_instr, ifid_pc, ifid_pc1, ifid_valid); end
        redirect = 1; redirect_pc = 9;
        tick();
        redirect = 0;
        checks++; if (halted !== 1 || ifid_valid !== 0 || imem_pc !== 32'd9)
            begin errors++; $display("FAIL redir_oor got h%b v%b pc%0d exp h1 v0 pc9", halted, ifid_valid, imem_pc); end
        repeat (2) tick();
        checks++; if (halted !== 1 || ifid_valid !== 0 || imem_pc !== 32'd9 || ifid_instr !== 32'd0)
            begin errors++; $display("FAIL oor_bubbles got h%b v%b pc%0d %h exp h1 v0 pc9 0", halted, ifid_valid, imem_pc, ifid_instr); end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (5) tick();
        stall = 1; redirect = 1; redirect_pc = 3;
        #3;
        rst_n = 0;
        #1;
        checks++; if (imem_pc !== 0 || ifid_instr !== 0 || ifid_pc !== 0 || ifid_pc1 !== 0 || ifid_valid !== 0 || halted !== 0)
            begin errors++; $display("FAIL async_reset got pc%0d %h ipc%0d pc1 %0d v%b h%b exp all 0", imem_pc, ifid_instr, ifid_pc, ifid_pc1, ifid_valid, halted); end
        @(negedge clk);
        stall = 0; redirect = 0; redirect_pc = 0;
        model_reset();
        rst_n = 1;
        tick();
        checks++; if (ifid_pc !== 0 || ifid_instr !== 32'h11 || ifid_valid !== 1)
            begin errors++; $display("FAIL async_first_fetch got ipc%0d %h v%b exp ipc0 11 v1", ifid_pc, ifid_instr, ifid_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) mem[i] = $urandom;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            stall = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 9) == 0);
            redirect_pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 11));
            tick();
            checks++; if (imem_pc !== m_pc || halted !== m_halt)
                begin errors++; $display("FAIL rand_pc c%0d got pc%0d h%b exp pc%0d h%b", c, imem_pc, halted, m_pc, m_halt); end
            checks++; if (ifid_instr !== m_instr || ifid_pc !== m_ipc || ifid_pc1 !== m_ipc1 || ifid_valid !== m_valid)
                begin errors++; $display("FAIL rand_ifid c%0d got %h %0d %0d v%b exp %h %0d %0d v%b", c, ifid_instr, ifid_pc, ifid_pc1, ifid_valid, m_instr, m_ipc, m_ipc1, m_valid); end
`ifdef FETCH_PERF_EN
            checks++; if (fcnt !== m_fc || scnt !== m_sc)
                begin errors++; $display("FAIL rand_perf c%0d got %0d/%0d exp %0d/%0d", c, fcnt, scnt, m_fc, m_sc); end
`endif
        end
        stall = 0; redirect = 0;
        load_mem_default();
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        do_reset();
        repeat (2) tick();
        stall = 1;
        repeat (2) tick();
        stall = 0;
        repeat (2) tick();
        redirect = 1; redirect_pc = 9;
        tick();
        redirect = 0;
        stall = 1;
        repeat (2) tick();
        stall = 0;
        repeat (2) tick();
        checks++; if (fcnt !== 32'd4 || scnt !== 32'd2)
            begin errors++; $display("FAIL perf_counts got %0d/%0d exp 4/2", fcnt, scnt); end
    endtask
`endif

    initial begin
        load_mem_default();
        model_reset();
        test_reset();
        test_run();
        test_stall();
        test_redirect_stall();
        test_halt_redirect();
        test_async_reset();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage: owns the program counter and drives the word-indexed PC into the combinational instruction memory.
- Captures the returned instruction into the IF/ID pipeline register for decode.
- Handles decode-stage stall, branch/jump redirect with flush, and end-of-program halt when PC leaves the memory range.

Parameters:
- PC_W, 32: width of PC and of all PC-carrying ports.
- INSTR_W, 32: instruction width.
- IMEM_DEPTH, 8: number of instruction words; valid PCs are 0..IMEM_DEPTH-1.
- RESET_PC, 0: PC after reset; must be < IMEM_DEPTH.
- NOP_INSTR, 32'h0000_0000: encoding injected as a bubble.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- stall_i  input  1  hold PC and IF/ID (hazard unit)
- redirect_i  input  1  taken branch/jump; load redirect_pc_i and flush IF/ID
- redirect_pc_i  input  PC_W  target word index
- imem_pc_o  output  PC_W  address to instruction memory (= pc_q)
- imem_instr_i  input  INSTR_W  combinational instruction memory data
- ifid_instr_o  output  INSTR_W  registered instruction
- ifid_pc_o  output  PC_W  PC of ifid_instr_o
- ifid_pc_plus1_o  output  PC_W  ifid_pc_o+1 (link/branch base)
- ifid_valid_o  output  1  1 = real instruction, 0 = bubble
- halted_o  output  1  fetch has run past IMEM_DEPTH-1

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low on rst_n; all state clears immediately on rst_n=0.
- Reset values:
  - pc_q=RESET_PC, state=FETCH
  - ifid_instr_o=NOP_INSTR, ifid_pc_o=0, ifid_pc_plus1_o=0
  - ifid_valid_o=0, halted_o=0
- PC output: imem_pc_o=pc_q combinationally. Memory is combinational, so IF/ID receives the instruction at PC n on the edge that ends the cycle in which pc_q=n (1-cycle fetch latency).
- FSM states: FETCH, HALT. halted_o=(state==HALT), registered.
- Per-edge priority, highest first:
  1. redirect_i=1 (in any state; overrides stall_i):
     - pc_q<=redirect_pc_i; IF/ID<=bubble (NOP_INSTR, valid 0, pc fields 0).
     - state<=FETCH if redirect_pc_i<IMEM_DEPTH, else HALT.
  2. stall_i=1: pc_q, IF/ID and state all hold.
  3. FETCH, no stall:
     - IF/ID<={imem_instr_i, pc_q, pc_q+1, valid 1}; pc_q<=pc_q+1.
     - If pc_q+1==IMEM_DEPTH, state<=HALT.
  4. HALT, no stall: pc_q holds; IF/ID<=bubble every cycle.
- Arithmetic: pc_q+1 is PC_W-bit modulo. A PC of all ones wraps to 0 but is already out of range, so it is in HALT.
- imem_instr_i is ignored in HALT; the memory is never read with an out-of-range PC while in FETCH.
- Simultaneous redirect and stall: redirect wins. The redirected instruction then waits for stall to drop.
- Reset asserted mid-stall or mid-redirect: immediate return to reset values. First fetch at RESET_PC on the first edge after rst_n rises.

Optional Feature:
- FETCH_PERF_EN defined:
  - Adds outputs fetch_count_o (32) and stall_count_o (32), both reset to 0.
  - fetch_count_o increments on each edge loading a valid instruction.
  - stall_count_o increments on each edge with stall_i=1 and redirect_i=0 while in FETCH.
  - Both saturate at 32'hFFFF_FFFF.
- FETCH_PERF_EN undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package (cpu_pkg):
  - PC_W, INSTR_W, NOP_INSTR
  - fetch state enum {FETCH, HALT}
  - ifid_t struct {instr, pc, pc_plus1, valid} for reuse by the decode stage
- One natural sub-module, ifid_reg: the pipeline register with load/hold/bubble controls. fetch_stage instantiates it; PC/FSM logic stays in the top.

Test Plan:
- Reset then run, memory words 0..7 = 0x11..0x18, no stall/redirect:
  - Edge 1: ifid_instr=0x11, pc=0, pc_plus1=1, valid=1.
  - Edge 8: ifid_instr=0x18, halted_o=1.
  - Edge 9 onward: valid=0, instr=NOP_INSTR, imem_pc_o stays 8.
- stall_i high for 3 cycles at pc_q=3: imem_pc_o=3 and IF/ID hold for 3 edges; next edge loads instr 0x14 with pc=3.
- redirect_i=1, redirect_pc_i=6 at pc_q=2 with stall_i=1 on the same edge:
  - That edge: IF/ID bubble, pc_q=6.
  - Next edge: 0x17, pc=6.
- From HALT, redirect to 1: halted_o=0 after the edge; the following edge loads 0x12, pc=1. Separately, redirect to 9 from FETCH: halted_o=1 and bubbles follow.
- Assert rst_n=0 asynchronously mid-cycle at pc_q=5:
  - Outputs go to reset values before the next edge.
  - After release, first load is pc=0.
- FETCH_PERF_EN defined: run 4 valid fetches with 2 stall cycles, then halt → fetch_count_o=4, stall_count_o=2. Counters are unchanged by redirect bubbles and HALT cycles.
